alu_result_stage: RTL
=====================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have no parameters; all datapath widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous clear of all buffered entries.
REQ-005 in_valid  input  1  upstream sum/carry/MSBs are valid this cycle.
REQ-006 in_ready  output  1  stage can accept an entry; registered.
REQ-007 in_result  input  32  sum output of the 32-bit adder.
REQ-008 in_cout  input  1  carry out of adder bit 31.
REQ-009 in_a_msb  input  1  operand A bit 31.
REQ-010 in_b_msb  input  1  operand B bit 31.
REQ-011 out_valid  output  1  output entry valid; registered.
REQ-012 out_ready  input  1  downstream accepts the entry this cycle.
REQ-013 out_result  output  32  registered sum.
REQ-014 out_cout  output  1  registered carry (unsigned overflow).
REQ-015 out_zero  output  1  1 when out_result == 0.
REQ-016 out_neg  output  1  out_result[31].
REQ-017 out_ovf  output  1  signed overflow: (a_msb == b_msb) and (result[31] != a_msb).

Function
REQ-018 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-019 Flags SHALL be computed from in_* at capture and stored with the entry; outputs SHALL be driven only from registers.
REQ-020 Storage SHALL be a 2-entry skid buffer: main register (drives outputs) and skid register.
REQ-021 State machine SHALL have states EMPTY, ONE, TWO; out_valid = (state != EMPTY); in_ready = (state != TWO).
REQ-022 EMPTY: input transfer -> load main, go ONE; otherwise stay.
REQ-023 ONE, input and output transfer -> load main with new entry, stay ONE.
REQ-024 ONE, input only -> load skid, go TWO.
REQ-025 ONE, output only -> go EMPTY.
REQ-026 TWO, output transfer -> move skid to main, go ONE; no input is accepted in TWO.
REQ-027 Latency SHALL be exactly 1 cycle: an entry accepted in EMPTY or ONE-with-drain appears on outputs the next cycle.
REQ-028 Throughput SHALL be one entry per cycle while out_ready is held 1.
REQ-029 Ordering SHALL be strictly FIFO; no entry SHALL be dropped or duplicated.
REQ-030 Output data and flags SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-031 flush = 1 SHALL force state EMPTY next cycle and ignore any simultaneous input transfer; data registers need not be cleared.
REQ-032 Data registers SHALL load only on the transfers above, for low toggle power.

Reset
REQ-033 While rst_n = 0: state = EMPTY, out_valid = 0, in_ready = 0, all data and flag outputs = 0.
REQ-034 in_ready SHALL become 1 on the first rising clk edge after rst_n deasserts.
REQ-035 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-036 Adder 0x7FFFFFFF + 0x00000001 (result 0x80000000, cout 0, a_msb 0, b_msb 0), out_ready = 1 -> next cycle out_valid 1, result 0x80000000, neg 1, ovf 1, zero 0, cout 0.
REQ-037 Adder 0xFFFFFFFF + 0x00000001 (result 0, cout 1, a_msb 1, b_msb 0) -> zero 1, cout 1, ovf 0, neg 0.
REQ-038 Backpressure: out_ready = 0, send entries 1, 2, 3 on consecutive cycles -> 1 in main, 2 in skid, in_ready drops after 2, and 3 is held upstream. Raise out_ready -> outputs 1, 2, 3 in order with no gaps.
REQ-039 Streaming: 100 random entries with in_valid and out_ready both held 1 -> one output per cycle, 1-cycle latency, all flags match a reference model.
REQ-040 flush while in TWO with in_valid = 1 -> next cycle out_valid 0, in_ready 1, and the flushed and offered entries never appear.
REQ-041 Assert rst_n = 0 mid-cycle while in ONE -> out_valid falls before the next edge. After release -> in_ready 1 after one edge.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered result stage behind a 32-bit adder: derives zero/neg/ovf flags at capture
// and buffers up to two entries in a main/skid pair so backpressure never drops data.
module alu_result_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_cout,
  input  logic        in_a_msb,
  input  logic        in_b_msb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_cout,
  output logic        out_zero,
  output logic        out_neg,
  output logic        out_ovf
);

  typedef struct packed {
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t r_state;
  entry_t r_main;
  entry_t r_skid;
  logic   r_in_ready;
  logic   r_out_valid;

  entry_t w_new;
  logic   w_in_xfer;
  logic   w_out_xfer;

  always_comb begin
    w_new.result = in_result;
    w_new.cout   = in_cout;
    w_new.zero   = (in_result == '0);
    w_new.neg    = in_result[31];
    w_new.ovf    = (in_a_msb == in_b_msb) && (in_result[31] != in_a_msb);
  end

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  // in_ready/out_valid are registered copies of the next state's decode, so both
  // are updated alongside r_state on every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          r_in_ready <= 1'b1;
          if (w_in_xfer) begin
            r_main      <= w_new;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= w_new;
          end else if (w_in_xfer) begin
            r_skid     <= w_new;
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (w_out_xfer) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_main.result;
  assign out_cout   = r_main.cout;
  assign out_zero   = r_main.zero;
  assign out_neg    = r_main.neg;
  assign out_ovf    = r_main.ovf;

endmodule
